mod9_wrap_display: RTL and testbench



---
 rtl/mod9_disp_pkg.sv | 23 ++
 rtl/mod9_wrap_display_if.sv | 13 +
 rtl/seg7_decode.sv | 26 ++
 rtl/mod9_wrap_display.sv | 90 +++++++++
 tb/tb_mod9_wrap_display.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mod9_disp_pkg.sv
// Shared constants for the mod-9 wrap display.
// Covers segment patterns {g,f,e,d,c,b,a}, digit enables and the refresh state type.
package mod9_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] DIG_UNITS = 2'b01;
  localparam logic [1:0] DIG_TENS  = 2'b10;

  typedef enum logic {ST_UNITS, ST_TENS} state_t;

endpackage

// File: rtl/mod9_wrap_display_if.sv
// Count input and display outputs of the mod-9 wrap display.
// The upstream/driver side uses master; the display block uses slave.
interface mod9_wrap_display_if;
  logic [3:0] Dat;
  logic [6:0] seg;
  logic [1:0] digSel;
  logic [3:0] wrapCnt;
  logic       wrapPulse;
  logic       errFlag;

  modport master (output Dat, input seg, digSel, wrapCnt, wrapPulse, errFlag);
  modport slave  (input Dat, output seg, digSel, wrapCnt, wrapPulse, errFlag);
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment lookup; codes above 9 show a dash.
module seg7_decode
  import mod9_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/mod9_wrap_display.sv
// Wrap counter and two-digit multiplexed display downstream of a mod-9 counter.
// Define MOD9_DISP_BLANK_EN to blank the tens digit while the wrap count is zero.
module mod9_wrap_display
  import mod9_disp_pkg::*;
#(
  parameter int MOD         = 9,
  parameter int REFRESH_DIV = 4
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  mod9_wrap_display_if.slave   bus
);

  localparam int              RW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0]   REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [3:0]      DAT_LAST = 4'(MOD - 1);
  localparam logic [4:0]      MOD_W    = 5'(MOD);

  state_t          state, state_nx;
  logic [RW-1:0]   ref_cnt, ref_nx;
  logic [3:0]      dat_q;
  logic [3:0]      wrap_cnt, wrap_nx;
  logic            wrap_pulse;
  logic            err_flag, err_nx;
  logic [6:0]      seg_q, seg_nx;
  logic [6:0]      seg_units, seg_tens;
  logic            wrap, illegal;

  // A wrap is the exact MOD-1 -> 0 step while the input stream is still trusted
  assign wrap    = (dat_q == DAT_LAST) && (bus.Dat == 4'd0) && !err_flag;
  assign illegal = ({1'b0, bus.Dat} >= MOD_W);
  assign err_nx  = err_flag | illegal;
  assign wrap_nx = wrap ? ((wrap_cnt == 4'd9) ? 4'd0 : wrap_cnt + 4'd1) : wrap_cnt;

  always_comb begin
    state_nx = state;
    ref_nx   = ref_cnt + RW'(1);
    if (ref_cnt == REF_LAST) begin
      ref_nx   = '0;
      state_nx = (state == ST_UNITS) ? ST_TENS : ST_UNITS;
    end
  end

  seg7_decode u_units (.code(bus.Dat), .seg(seg_units));
  seg7_decode u_tens  (.code(wrap_nx), .seg(seg_tens));

  // seg is built from next-cycle values so it moves on the same edge as digSel
  always_comb begin
    seg_nx = seg_tens;
    if (err_nx) begin
      seg_nx = SEG_DASH;
    end else if (state_nx == ST_UNITS) begin
      seg_nx = seg_units;
    end else begin
`ifdef MOD9_DISP_BLANK_EN
      if (wrap_nx == 4'd0) seg_nx = SEG_BLANK;
      else                 seg_nx = seg_tens;
`else
      seg_nx = seg_tens;
`endif
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state      <= ST_UNITS;
      ref_cnt    <= '0;
      dat_q      <= 4'd0;
      wrap_cnt   <= 4'd0;
      wrap_pulse <= 1'b0;
      err_flag   <= 1'b0;
      seg_q      <= SEG_0;
    end else begin
      state      <= state_nx;
      ref_cnt    <= ref_nx;
      dat_q      <= bus.Dat;
      wrap_cnt   <= wrap_nx;
      wrap_pulse <= wrap;
      err_flag   <= err_nx;
      seg_q      <= seg_nx;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.digSel    = (state == ST_TENS) ? DIG_TENS : DIG_UNITS;
  assign bus.wrapCnt   = wrap_cnt;
  assign bus.wrapPulse = wrap_pulse;
  assign bus.errFlag   = err_flag;

endmodule

// File: tb/tb_mod9_wrap_display.sv
// Directed bench for mod9_wrap_display: vector table plus wrap, skip, error and reset sequences.
module tb_mod9_wrap_display;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] SD = 7'b1000000;
`ifdef MOD9_DISP_BLANK_EN
  localparam logic [6:0] T0 = 7'b0000000;
`else
  localparam logic [6:0] T0 = 7'b0111111;
`endif

  typedef struct {
    logic [3:0] dat;
    logic [1:0] dsel;
    logic [6:0] seg;
    logic       pulse;
    logic [3:0] wc;
  } vec_t;

  logic clkIn = 1'b0;
  logic rstIn = 1'b1;
  int   nchk  = 0;
  int   nfail = 0;
  int   npulse;
  vec_t tbl [20];

  mod9_wrap_display_if bus ();

  mod9_wrap_display #(.MOD(9), .REFRESH_DIV(4)) dut (
    .clkIn (clkIn),
    .rstIn (rstIn),
    .bus   (bus)
  );

  always #5 clkIn = ~clkIn;

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstIn   = 1'b1;
    bus.Dat = 4'd0;
    tick();
    rstIn = 1'b0;
  endtask

  task automatic run_seq(input int target_wc);
    for (int d = 1; d <= 8; d++) begin
      bus.Dat = 4'(d);
      tick();
      chk("seq_no_pulse", 32'(bus.wrapPulse), 32'd0);
    end
    bus.Dat = 4'd0;
    tick();
    chk("seq_pulse", 32'(bus.wrapPulse), 32'd1);
    chk("seq_wc", 32'(bus.wrapCnt), 32'(target_wc));
  endtask

  initial begin
    tbl[0]  = '{4'd0, 2'b01, S0, 1'b0, 4'd0};
    tbl[1]  = '{4'd0, 2'b01, S0, 1'b0, 4'd0};
    tbl[2]  = '{4'd0, 2'b01, S0, 1'b0, 4'd0};
    tbl[3]  = '{4'd0, 2'b10, T0, 1'b0, 4'd0};
    tbl[4]  = '{4'd0, 2'b10, T0, 1'b0, 4'd0};
    tbl[5]  = '{4'd0, 2'b10, T0, 1'b0, 4'd0};
    tbl[6]  = '{4'd0, 2'b10, T0, 1'b0, 4'd0};
    tbl[7]  = '{4'd0, 2'b01, S0, 1'b0, 4'd0};
    tbl[8]  = '{4'd1, 2'b01, S1, 1'b0, 4'd0};
    tbl[9]  = '{4'd2, 2'b01, S2, 1'b0, 4'd0};
    tbl[10] = '{4'd3, 2'b01, S3, 1'b0, 4'd0};
    tbl[11] = '{4'd4, 2'b10, T0, 1'b0, 4'd0};
    tbl[12] = '{4'd5, 2'b10, T0, 1'b0, 4'd0};
    tbl[13] = '{4'd6, 2'b10, T0, 1'b0, 4'd0};
    tbl[14] = '{4'd7, 2'b10, T0, 1'b0, 4'd0};
    tbl[15] = '{4'd8, 2'b01, S8, 1'b0, 4'd0};
    tbl[16] = '{4'd0, 2'b01, S0, 1'b1, 4'd1};
    tbl[17] = '{4'd0, 2'b01, S0, 1'b0, 4'd1};
    tbl[18] = '{4'd0, 2'b01, S0, 1'b0, 4'd1};
    tbl[19] = '{4'd0, 2'b10, S1, 1'b0, 4'd1};

    // reset state
    rstIn   = 1'b1;
    bus.Dat = 4'd5;
    tick();
    tick();
    chk("rst_seg", 32'(bus.seg), 32'(S0));
    chk("rst_dsel", 32'(bus.digSel), 32'd1);
    chk("rst_wc", 32'(bus.wrapCnt), 32'd0);
    chk("rst_pulse", 32'(bus.wrapPulse), 32'd0);
    chk("rst_err", 32'(bus.errFlag), 32'd0);
    rstIn   = 1'b0;
    bus.Dat = 4'd0;

    // refresh alternation and first wrap
    for (int i = 0; i < 20; i++) begin
      bus.Dat = tbl[i].dat;
      tick();
      chk($sformatf("vec%0d_dsel", i), 32'(bus.digSel), 32'(tbl[i].dsel));
      chk($sformatf("vec%0d_seg", i), 32'(bus.seg), 32'(tbl[i].seg));
      chk($sformatf("vec%0d_pulse", i), 32'(bus.wrapPulse), 32'(tbl[i].pulse));
      chk($sformatf("vec%0d_wc", i), 32'(bus.wrapCnt), 32'(tbl[i].wc));
      chk($sformatf("vec%0d_err", i), 32'(bus.errFlag), 32'd0);
    end

    // ten full sequences: wrap count 1..9 then back to 0
    do_reset();
    npulse = 0;
    for (int s = 1; s <= 10; s++) begin
      run_seq(s % 10);
      if (bus.wrapPulse === 1'b1) npulse++;
    end
    chk("ten_wrap_pulses", 32'(npulse), 32'd10);

    // 8->1 ignored, held 8 then 0 counted once
    do_reset();
    bus.Dat = 4'd8;
    tick();
    bus.Dat = 4'd1;
    tick();
    chk("skip_pulse", 32'(bus.wrapPulse), 32'd0);
    chk("skip_wc", 32'(bus.wrapCnt), 32'd0);
    bus.Dat = 4'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold8_pulse", 32'(bus.wrapPulse), 32'd0);
    end
    bus.Dat = 4'd0;
    tick();
    chk("hold8_wrap_pulse", 32'(bus.wrapPulse), 32'd1);
    chk("hold8_wrap_wc", 32'(bus.wrapCnt), 32'd1);
    tick();
    chk("hold8_pulse_one_cycle", 32'(bus.wrapPulse), 32'd0);

    // illegal code: sticky error, dash display, frozen wrap count
    bus.Dat = 4'b1011;
    tick();
    chk("err_set", 32'(bus.errFlag), 32'd1);
    bus.Dat = 4'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("err_dash", 32'(bus.seg), 32'(SD));
      chk("err_sticky", 32'(bus.errFlag), 32'd1);
    end
    bus.Dat = 4'd8;
    tick();
    bus.Dat = 4'd0;
    tick();
    chk("err_no_pulse", 32'(bus.wrapPulse), 32'd0);
    chk("err_wc_frozen", 32'(bus.wrapCnt), 32'd1);
    chk("err_dash_after", 32'(bus.seg), 32'(SD));
    rstIn = 1'b1;
    tick();
    chk("err_rst_seg", 32'(bus.seg), 32'(S0));
    chk("err_rst_dsel", 32'(bus.digSel), 32'd1);
    chk("err_rst_wc", 32'(bus.wrapCnt), 32'd0);
    chk("err_rst_pulse", 32'(bus.wrapPulse), 32'd0);
    chk("err_rst_err", 32'(bus.errFlag), 32'd0);
    rstIn = 1'b0;

    // mid-operation reset with wrapCnt=5 in the tens phase, right on a wrap
    for (int s = 1; s <= 5; s++) run_seq(s);
    chk("mid_wc5", 32'(bus.wrapCnt), 32'd5);
    chk("mid_dsel_tens", 32'(bus.digSel), 32'd2);
    rstIn   = 1'b1;
    bus.Dat = 4'd3;
    tick();
    chk("mid_rst_wc", 32'(bus.wrapCnt), 32'd0);
    chk("mid_rst_dsel", 32'(bus.digSel), 32'd1);
    chk("mid_rst_pulse", 32'(bus.wrapPulse), 32'd0);
    chk("mid_rst_seg", 32'(bus.seg), 32'(S0));
    rstIn   = 1'b0;
    bus.Dat = 4'd0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("mid_phase%0d_dsel", i), 32'(bus.digSel), (i == 4) ? 32'd2 : 32'd1);
    end
    chk("mid_phase4_seg", 32'(bus.seg), 32'(T0));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
